// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, excepttype codes, bit positions and MTC0 write masks.
package cp0_defs;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned CAUSE_BD   = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Interrupt is reported as ExcCode 0; the other codes map onto themselves.
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    return (t == EXC_INT) ? 5'd0 : t[4:0];
  endfunction

  function automatic logic [31:0] cp0_wmask(input logic [4:0] addr);
    case (addr)
      CP0_COUNT, CP0_COMPARE, CP0_EPC: return '1;
      CP0_STATUS:                      return STATUS_WMASK;
      CP0_CAUSE:                       return CAUSE_WMASK;
      default:                         return '0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: clock divider, Count register, Compare register and sticky TI latch.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [1:0]  div_q, div_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end else if (div_q == 2'(COUNT_DIV - 1)) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      div_d = div_q + 2'd1;
    end
    if (compare_we_i) compare_d = wdata_i;
    // Match is taken on the post-update values; a Compare write always wins.
    ti_d = compare_we_i ? 1'b0 : (ti_q | (count_d == compare_d));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, exception/ERET commit and live Status/Cause/EPC export.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_4220,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count, compare;
  logic        ti;
  logic        exc_commit, eret_commit;
  logic [31:0] rd_cur, rmask;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
    .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  assign exc_commit  = (excepttype_i != '0) && (excepttype_i != EXC_ERET);
  assign eret_commit = (excepttype_i == EXC_ERET);

  // TI and its contribution to IP[7] live in the timer; merge them into the visible Cause.
  assign cause_o     = cause_q | {1'b0, ti, 14'd0, ti, 15'd0};
  assign status_o    = status_q;
  assign epc_o       = epc_q;
  assign timer_int_o = ti;

  always_comb begin
    case (raddr_i)
      CP0_BADVADDR: rd_cur = badvaddr_q;
      CP0_COUNT:    rd_cur = count;
      CP0_COMPARE:  rd_cur = compare;
      CP0_STATUS:   rd_cur = status_q;
      CP0_CAUSE:    rd_cur = cause_o;
      CP0_EPC:      rd_cur = epc_q;
      CP0_PRID:     rd_cur = PRID;
      default:      rd_cur = '0;
    endcase
    rmask   = (we_i && (waddr_i == raddr_i)) ? cp0_wmask(raddr_i) : '0;
    rdata_o = (wdata_i & rmask) | (rd_cur & ~rmask);
  end

  // MTC0 is applied first; commit/ERET then overrides only the fields it owns.
  always_comb begin
    status_d      = status_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    cause_d[15:10] = int_i;
    if (we_i) begin
      case (waddr_i)
        CP0_STATUS: status_d = (wdata_i & STATUS_WMASK) | (status_q & ~STATUS_WMASK);
        CP0_CAUSE:  cause_d  = (wdata_i & CAUSE_WMASK) | (cause_d & ~CAUSE_WMASK);
        CP0_EPC:    epc_d    = wdata_i;
        default:    ;
      endcase
    end
    if (exc_commit) begin
      status_d[STATUS_EXL] = 1'b1;
      cause_d[6:2]         = exc_code(excepttype_i);
      if (!status_q[STATUS_EXL]) begin
        epc_d             = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) badvaddr_d = badvaddr_i;
    end else if (eret_commit) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed scenarios plus random traffic against a field-level model.
module tb_cp0_regfile;

  localparam logic [31:0] PRID_V = 32'h0000_4220;
  localparam int unsigned DIV_V  = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  ints = '0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [31:0] exc = '0;
  logic [31:0] pc = '0;
  logic        ds = 1'b0;
  logic [31:0] badv = '0;
  logic [31:0] status, cause, epc;
  logic        timer_int;

  always #5 clk = ~clk;

  cp0_regfile #(.PRID(PRID_V), .COUNT_DIV(DIV_V)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .int_i             (ints),
    .we_i              (we),
    .waddr_i           (waddr),
    .wdata_i           (wdata),
    .raddr_i           (raddr),
    .rdata_o           (rdata),
    .excepttype_i      (exc),
    .pc_i              (pc),
    .is_in_delayslot_i (ds),
    .badvaddr_i        (badv),
    .status_o          (status),
    .cause_o           (cause),
    .epc_o             (epc),
    .timer_int_o       (timer_int)
  );

  // Reference model: architectural fields kept separately.
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  int unsigned m_since_inc;
  logic        m_ti, m_exl, m_ie, m_bd;
  logic [7:0]  m_im;
  logic [4:0]  m_code;
  logic [1:0]  m_sw;
  logic [5:0]  m_int;

  typedef struct {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] rdata;
    logic        timer;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  function automatic void model_reset();
    m_count = '0; m_compare = '0; m_epc = '0; m_badv = '0; m_since_inc = 0;
    m_ti = 1'b0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_im = '0; m_code = '0; m_sw = '0; m_int = '0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0040_0000;
    s[15:8] = m_im;
    s[1] = m_exl;
    s[0] = m_ie;
    return s;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = '0;
    c[31] = m_bd;
    c[30] = m_ti;
    c[15] = m_int[5] | m_ti;
    c[14:10] = m_int[4:0];
    c[9:8] = m_sw;
    c[6:2] = m_code;
    return c;
  endfunction

  function automatic logic [4:0] code_of(input logic [31:0] t);
    case (t)
      32'h01:  return 5'd0;
      32'h04:  return 5'd4;
      32'h05:  return 5'd5;
      32'h08:  return 5'd8;
      32'h09:  return 5'd9;
      32'h0A:  return 5'd10;
      32'h0C:  return 5'd12;
      default: return t[4:0];
    endcase
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] v;
    case (raddr)
      5'd8:    v = m_badv;
      5'd9:    v = m_count;
      5'd11:   v = m_compare;
      5'd12:   v = m_status();
      5'd13:   v = m_cause();
      5'd14:   v = m_epc;
      5'd15:   v = PRID_V;
      default: v = '0;
    endcase
    if (we && waddr == raddr) begin
      case (raddr)
        5'd9, 5'd11, 5'd14: v = wdata;
        5'd12: begin v[15:8] = wdata[15:8]; v[1:0] = wdata[1:0]; end
        5'd13: v[9:8] = wdata[9:8];
        default: ;
      endcase
    end
    return v;
  endfunction

  // One clock edge worth of architectural behaviour, using the inputs held across it.
  function automatic void model_step();
    logic old_exl;
    old_exl = m_exl;
    m_int = ints;
    if (we && waddr == 5'd9) begin
      m_count = wdata;
      m_since_inc = 0;
    end else begin
      m_since_inc++;
      if (m_since_inc == DIV_V) begin
        m_count = m_count + 1;
        m_since_inc = 0;
      end
    end
    if (we && waddr == 5'd11) m_compare = wdata;
    if (we && waddr == 5'd11) m_ti = 1'b0;
    else if (m_count == m_compare) m_ti = 1'b1;
    if (we) begin
      case (waddr)
        5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
        5'd13: m_sw = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
    end
    if (exc == 32'h0E) begin
      m_exl = 1'b0;
    end else if (exc != 0) begin
      m_exl = 1'b1;
      m_code = code_of(exc);
      if (!old_exl) begin
        m_epc = ds ? pc - 32'd4 : pc;
        m_bd = ds;
      end
      if (exc == 32'h04 || exc == 32'h05) m_badv = badv;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.status = m_status();
    e.cause  = m_cause();
    e.epc    = m_epc;
    e.rdata  = m_read();
    e.timer  = m_ti;
    sb.push_back(e);
  endfunction

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [31:0] ex, input logic [31:0] p,
                       input logic d, input logic [31:0] bv, input logic [5:0] it);
    we = w; waddr = wa; wdata = wd; raddr = ra;
    exc = ex; pc = p; ds = d; badv = bv; ints = it;
    push_expect();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, '0, ra, '0, '0, 1'b0, '0, ints);
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    drive(1'b1, wa, wd, ra, '0, '0, 1'b0, '0, ints);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    we = 1'b0; exc = '0; raddr = 5'd12; ints = '0;
    model_reset();
    push_expect();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares one scoreboard entry per cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("status", status, e.status);
        chk("cause", cause, e.cause);
        chk("epc", epc, e.epc);
        chk("rdata", rdata, e.rdata);
        chk("timer_int", {31'd0, timer_int}, {31'd0, e.timer});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] regs [7];
    logic [31:0] codes [8];
    logic [4:0] wa, ra;
    logic [31:0] wd, ex;
    regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    codes = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0A, 32'h0C, 32'h0E};
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Timer: Compare=5, Count=0, then watch TI rise as Count reaches 5.
    mtc0(5'd11, 32'd5, 5'd11);
    mtc0(5'd9, 32'd0, 5'd9);
    idle(12, 5'd9);
    mtc0(5'd11, 32'd9, 5'd13);
    idle(2, 5'd13);

    // Delay-slot exception, then a nested one that must keep EPC.
    drive(1'b0, 5'd0, '0, 5'd14, 32'h0C, 32'hBFC0_0100, 1'b1, '0, 6'h00);
    idle(1, 5'd13);
    drive(1'b0, 5'd0, '0, 5'd14, 32'h08, 32'h0000_1234, 1'b0, '0, 6'h15);
    idle(1, 5'd14);

    // Address error captures BadVAddr; ERET clears EXL only.
    drive(1'b0, 5'd0, '0, 5'd8, 32'h04, 32'h0000_2000, 1'b0, 32'h0000_0003, 6'h2A);
    idle(1, 5'd8);
    drive(1'b0, 5'd0, '0, 5'd12, 32'h0E, '0, 1'b0, '0, 6'h00);
    idle(1, 5'd14);

    // MTC0 Status together with an exception commit.
    drive(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h08, 32'h0000_3000, 1'b0, '0, 6'h00);
    idle(1, 5'd12);

    // Count wrap, read-only PRId, Cause software bits.
    mtc0(5'd9, 32'hFFFF_FFFF, 5'd9);
    idle(3, 5'd9);
    mtc0(5'd15, 32'h0, 5'd15);
    idle(1, 5'd15);
    mtc0(5'd8, 32'hDEAD_BEEF, 5'd8);
    mtc0(5'd13, 32'hFFFF_FFFF, 5'd13);
    idle(1, 5'd13);
    mtc0(5'd20, 32'h1234_5678, 5'd20);

    // Pending timer interrupt wiped by an asynchronous reset.
    mtc0(5'd11, 32'd3, 5'd11);
    mtc0(5'd9, 32'd3, 5'd13);
    idle(2, 5'd13);
    apply_reset();
    idle(2, 5'd12);

    for (int n = 0; n < 3000; n++) begin
      wa = ($urandom_range(0, 9) < 7) ? regs[$urandom_range(0, 6)] : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 9) < 7) ? regs[$urandom_range(0, 6)] : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = wa;
      wd = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 24));
      ex = ($urandom_range(0, 6) == 0) ? codes[$urandom_range(0, 7)] : 32'h0;
      drive($urandom_range(0, 9) < 3, wa, wd, ra, ex, {$urandom, 2'b00} >> 2 << 2,
            1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)));
    end
    idle(1, 5'd12);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
